// File: rtl/hs_npu_pkg.sv
// rtl/hs_npu_pkg.sv - shared types for the NPU layer descriptor queue
//
// Purpose: descriptor layout and sequencer state type shared by the queue,
//          its FIFO and the handshake interface.
// Ports:   none (package).
package hs_npu_pkg;

  typedef logic [31:0] uword;

  typedef struct packed {
    uword num_input_rows;
    uword num_input_columns;
    uword num_weight_rows;
    uword num_weight_columns;
    logic reuse_inputs;
    logic reuse_weights;
    logic save_outputs;
    logic use_bias;
    logic use_sum;
    uword shift_amount;
    logic activation_select;
    uword base_address;
    uword result_address;
    logic chain;
  } layer_desc_t;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_DONE = 2'd2
  } layer_queue_state_e;

  localparam int LAYER_DESC_W = $bits(layer_desc_t);

endpackage

// File: rtl/hs_npu_layer_queue_if.sv
// rtl/hs_npu_layer_queue_if.sv - descriptor and exec handshake bundle
//
// Purpose: groups the CPU descriptor push handshake and the core exec/done
//          handshake of the layer queue.
// Signals: desc_valid/desc_ready/desc (CPU push), exec_valid/exec_ready/
//          exec_desc (issue to core), core_done (layer completion pulse).
// Modports: slave = the layer queue, master = the CPU/core environment.
interface hs_npu_layer_queue_if;
  import hs_npu_pkg::*;

  logic        desc_valid;
  logic        desc_ready;
  layer_desc_t desc;
  logic        exec_valid;
  logic        exec_ready;
  layer_desc_t exec_desc;
  logic        core_done;

  modport master (
    output desc_valid, desc, exec_ready, core_done,
    input  desc_ready, exec_valid, exec_desc
  );

  modport slave (
    input  desc_valid, desc, exec_ready, core_done,
    output desc_ready, exec_valid, exec_desc
  );

endinterface

// File: rtl/hs_npu_desc_fifo.sv
// rtl/hs_npu_desc_fifo.sv - synchronous descriptor FIFO with flush
//
// Purpose: DEPTH-entry FIFO; full is derived from the occupancy count.
// Ports:   clk, rst (sync active-high), push_i/data_i (write), pop_i/data_o
//          (read, data_o shows the head combinationally), flush_i (clears
//          pointers and count), count_o (occupancy), full_o.
module hs_npu_desc_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = PW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  input  logic             flush_i,
  output logic [CW-1:0]    count_o,
  output logic             full_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == CW'(DEPTH));
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && (count_q != '0);
  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // Flush only resets bookkeeping; the popped head is read combinationally
  // this cycle, so a pop coinciding with flush still delivers its entry.
  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_q + CW'(push_ok) - CW'(pop_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok && !flush_i) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/hs_npu_layer_queue.sv
// rtl/hs_npu_layer_queue.sv - layer descriptor queue and issue sequencer
//
// Purpose: buffers layer descriptors, issues them one at a time to the NPU
//          core and waits for each completion, optionally chaining the last
//          result address into the next base address.
// Ports:   clk, rst (sync active-high); bus (slave: descriptor push, exec
//          issue, core_done); flush_i; count_o, idle_o, drained_o;
//          layers_done_o, busy_cycles_o, stall_cycles_o.
// Config:  HS_NPU_LAYER_QUEUE_PERF_EN enables the busy/stall counters;
//          otherwise those outputs are tied to zero.
module hs_npu_layer_queue
  import hs_npu_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int CNT_WIDTH = 32,
  localparam int CW       = $clog2(DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  hs_npu_layer_queue_if.slave  bus,
  input  logic                 flush_i,
  output logic [CW-1:0]        count_o,
  output logic                 idle_o,
  output logic                 drained_o,
  output logic [CNT_WIDTH-1:0] layers_done_o,
  output logic [CNT_WIDTH-1:0] busy_cycles_o,
  output logic [CNT_WIDTH-1:0] stall_cycles_o
);

  localparam logic [1:0] ST_IDLE  = 2'(IDLE);
  localparam logic [1:0] ST_ISSUE = 2'(ISSUE);
  localparam logic [1:0] ST_WAIT  = 2'(WAIT_DONE);

  logic [1:0]           state_q, state_d;
  layer_desc_t          exec_desc_q, exec_desc_d, head;
  uword                 last_result_q, last_result_d;
  logic                 done_seen_q, done_seen_d;
  logic                 drained_q, drained_d;
  logic [CNT_WIDTH-1:0] layers_q, layers_d;
  logic                 full, pop;

  hs_npu_desc_fifo #(.DEPTH(DEPTH), .WIDTH(LAYER_DESC_W)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (bus.desc_valid),
    .data_i  (bus.desc),
    .pop_i   (pop),
    .data_o  (head),
    .flush_i (flush_i),
    .count_o (count_o),
    .full_o  (full)
  );

  assign bus.desc_ready = !full;
  assign bus.exec_valid = (state_q == ST_ISSUE);
  assign bus.exec_desc  = exec_desc_q;
  assign idle_o         = (state_q == ST_IDLE) && (count_o == '0);
  assign drained_o      = drained_q;
  assign layers_done_o  = layers_q;

  always_comb begin
    state_d       = state_q;
    exec_desc_d   = exec_desc_q;
    last_result_d = last_result_q;
    done_seen_d   = done_seen_q;
    layers_d      = layers_q;
    drained_d     = 1'b0;
    pop           = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (count_o != '0) begin
          pop     = 1'b1;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (bus.exec_ready) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (bus.core_done) begin
          layers_d      = layers_q + CNT_WIDTH'(1);
          last_result_d = exec_desc_q.result_address;
          done_seen_d   = 1'b1;
          if (count_o != '0) begin
            pop     = 1'b1;
            state_d = ST_ISSUE;
          end else begin
            drained_d = 1'b1;
            state_d   = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Chain from the next-state values so a back-to-back issue picks up the
    // result address of the layer completing in this very cycle.
    if (pop) begin
      exec_desc_d = head;
      if (head.chain && done_seen_d) exec_desc_d.base_address = last_result_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      exec_desc_q   <= '0;
      last_result_q <= '0;
      done_seen_q   <= 1'b0;
      layers_q      <= '0;
      drained_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      exec_desc_q   <= exec_desc_d;
      last_result_q <= last_result_d;
      done_seen_q   <= done_seen_d;
      layers_q      <= layers_d;
      drained_q     <= drained_d;
    end
  end

`ifdef HS_NPU_LAYER_QUEUE_PERF_EN
  logic [CNT_WIDTH-1:0] busy_q, stall_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q  <= '0;
      stall_q <= '0;
    end else begin
      if ((state_q != ST_IDLE) && (busy_q != '1)) busy_q <= busy_q + CNT_WIDTH'(1);
      if ((state_q == ST_ISSUE) && !bus.exec_ready && (stall_q != '1))
        stall_q <= stall_q + CNT_WIDTH'(1);
    end
  end

  assign busy_cycles_o  = busy_q;
  assign stall_cycles_o = stall_q;
`else
  assign busy_cycles_o  = '0;
  assign stall_cycles_o = '0;
`endif

endmodule
